// File: rtl/bright_adj_pipe_pkg.sv
// Shared constants and helpers for the brightness-adjust video pipeline.
// Holds the RGB565 field positions, channel widths, the fixed pipeline latency,
// the signed level type and the 5/6-bit to 8-bit channel expansion helpers.
package bright_adj_pipe_pkg;

  localparam int unsigned PixW = 16;

  // RGB565 field positions
  localparam int unsigned RMsb = 15;
  localparam int unsigned RLsb = 11;
  localparam int unsigned GMsb = 10;
  localparam int unsigned GLsb = 5;
  localparam int unsigned BMsb = 4;
  localparam int unsigned BLsb = 0;

  // Channel widths
  localparam int unsigned RW    = 5;
  localparam int unsigned GW    = 6;
  localparam int unsigned BW    = 5;
  localparam int unsigned ChanW = 8;

  localparam int unsigned NumChan = 3;
  localparam int unsigned Latency = 2;

  // Level is 4-bit two's complement; the sum carries one guard bit beyond 10
  // so 255 + 7*63 cannot wrap before the clamp.
  localparam int unsigned LvlW = 4;
  localparam int unsigned SumW = 11;

  typedef logic signed [LvlW-1:0] lvl_t;

  typedef struct packed {
    logic data_en;
    logic vs;
    logic de;
  } sync_t;

  // MSB replication so full-scale input maps to 255 and pass-through is exact.
  function automatic logic [ChanW-1:0] expand5(input logic [RW-1:0] c);
    return {c, c[RW-1 -: 3]};
  endfunction

  function automatic logic [ChanW-1:0] expand6(input logic [GW-1:0] c);
    return {c, c[GW-1 -: 2]};
  endfunction

endpackage

// File: rtl/bright_adj_pipe_if.sv
// Pixel/sync/key/level bundle for bright_adj_pipe.
// slave  : the pipeline side (pixel, sync and keys in; adjusted pixel, sync, level out)
// master : the source/sink side driving inputs and observing outputs
interface bright_adj_pipe_if import bright_adj_pipe_pkg::*;;

  logic [PixW-1:0] rgb_data_i;
  logic            data_en_i;
  logic            vs_in;
  logic            de_in;
  logic            key_up;
  logic            key_dn;
  logic [PixW-1:0] rgb_data_o;
  logic            data_en_o;
  logic            vs_o;
  logic            de_o;
  logic [LvlW-1:0] level_o;

  modport slave (
    input  rgb_data_i, data_en_i, vs_in, de_in, key_up, key_dn,
    output rgb_data_o, data_en_o, vs_o, de_o, level_o
  );

  modport master (
    output rgb_data_i, data_en_i, vs_in, de_in, key_up, key_dn,
    input  rgb_data_o, data_en_o, vs_o, de_o, level_o
  );

endinterface

// File: rtl/bright_level_ctrl.sv
// Brightness level control.
// Keeps a saturating pending level driven by key pulses and commits it to the
// active level on each vs rising edge, so a frame never changes level midway.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   key_up_i    : one-cycle pulse, pending level +1 (saturating)
//   key_dn_i    : one-cycle pulse, pending level -1 (saturating)
//   vs_i        : vertical sync, rising edge commits the pending level
//   lvl_act_o   : active level (registered)
module bright_level_ctrl import bright_adj_pipe_pkg::*; #(
  parameter int unsigned MAX_LVL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_up_i,
  input  logic key_dn_i,
  input  logic vs_i,
  output lvl_t lvl_act_o
);

  localparam int   MaxInt = int'(MAX_LVL);
  localparam lvl_t MaxLvl = LvlW'(MaxInt);
  localparam lvl_t MinLvl = LvlW'(-MaxInt);

  lvl_t pend_q, pend_d, act_q;
  logic vs_q, vs_rise;

  always_comb begin
    pend_d = pend_q;
    if (key_up_i && !key_dn_i && (pend_q < MaxLvl)) begin
      pend_d = pend_q + lvl_t'(1);
    end else if (key_dn_i && !key_up_i && (pend_q > MinLvl)) begin
      pend_d = pend_q - lvl_t'(1);
    end
  end

  assign vs_rise = vs_i & ~vs_q;

  // A key pulse on the vs edge updates pend_q, but act_q takes the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      act_q  <= '0;
      vs_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      vs_q   <= vs_i;
      if (vs_rise) begin
        act_q <= pend_q;
      end
    end
  end

  assign lvl_act_o = act_q;

endmodule

// File: rtl/bright_adj_pipe.sv
// Two-stage RGB565 brightness adjust.
// Stage 1 adds a signed offset (level * STEP) to each 8-bit-expanded channel,
// stage 2 clamps to 0..255 and repacks to RGB565. Sync qualifiers ride along
// with the same 2-cycle delay. The pipeline never stalls.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bright_adj_pipe_if (pixel/sync/keys in, pixel/sync/level out)
module bright_adj_pipe import bright_adj_pipe_pkg::*; #(
  parameter int unsigned STEP    = 10,
  parameter int unsigned MAX_LVL = 4
) (
  input logic               clk,
  input logic               rst,
  bright_adj_pipe_if.slave  bus
);

  lvl_t                  lvl_act;
  logic signed [SumW-1:0] offset;
  sync_t                 sync_in, s1_sync_q, s2_sync_q;
  logic [PixW-1:0]       rgb_d, rgb_q;

  bright_level_ctrl #(
    .MAX_LVL (MAX_LVL)
  ) u_level_ctrl (
    .clk       (clk),
    .rst       (rst),
    .key_up_i  (bus.key_up),
    .key_dn_i  (bus.key_dn),
    .vs_i      (bus.vs_in),
    .lvl_act_o (lvl_act)
  );

  always_comb begin
    offset = $signed(SumW'(lvl_act)) * $signed(SumW'(STEP));
  end

  always_comb begin
    sync_in.data_en = bus.data_en_i;
    sync_in.vs      = bus.vs_in;
    sync_in.de      = bus.de_in;
  end

  for (genvar i = 0; i < NumChan; i++) begin : g_chan
    localparam int unsigned W = (i == 1) ? GW : RW;

    logic [ChanW-1:0]       c8;
    logic signed [SumW-1:0] sum_q;
    logic [ChanW-1:0]       sat;
    logic [W-1:0]           field;
    logic                   unused_lsbs;

    if (i == 0) begin : g_r
      assign c8 = expand5(bus.rgb_data_i[RMsb:RLsb]);
    end else if (i == 1) begin : g_g
      assign c8 = expand6(bus.rgb_data_i[GMsb:GLsb]);
    end else begin : g_b
      assign c8 = expand5(bus.rgb_data_i[BMsb:BLsb]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
      end else begin
        sum_q <= $signed({{(SumW-ChanW){1'b0}}, c8}) + offset;
      end
    end

    // Negative -> 0, anything with bits above the byte set -> 255.
    always_comb begin
      sat = sum_q[ChanW-1:0];
      if (sum_q[SumW-1]) begin
        sat = '0;
      end else if (|sum_q[SumW-2:ChanW]) begin
        sat = '1;
      end
    end

    assign field       = sat[ChanW-1 -: W];
    assign unused_lsbs = ^sat[ChanW-W-1:0];
  end

  assign rgb_d = {g_chan[0].field, g_chan[1].field, g_chan[2].field};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sync_q <= '0;
      s2_sync_q <= '0;
      rgb_q     <= '0;
    end else begin
      s1_sync_q <= sync_in;
      s2_sync_q <= s1_sync_q;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.rgb_data_o = rgb_q;
  assign bus.data_en_o  = s2_sync_q.data_en;
  assign bus.vs_o       = s2_sync_q.vs;
  assign bus.de_o       = s2_sync_q.de;
  assign bus.level_o    = lvl_act;

endmodule

// File: tb/tb_bright_adj_pipe.sv
// Self-checking bench for bright_adj_pipe: directed steps with a scoreboard
// queue of expected outputs built from an independent reference model.
module tb_bright_adj_pipe;
  import bright_adj_pipe_pkg::*;

  localparam int unsigned Step   = 10;
  localparam int          MaxLvl = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bright_adj_pipe_if bus ();

  bright_adj_pipe #(
    .STEP    (Step),
    .MAX_LVL (MaxLvl)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rgb;
    logic [2:0]  sync;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pend = 0;
  int          act = 0;
  bit          vs_prev = 1'b0;
  logic [15:0] last_rgb = 16'h0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [15:0] model_pix(input logic [15:0] p, input int lvl);
    int r8, g8, b8, off;
    r8  = (int'(p[15:11]) << 3) | (int'(p[15:11]) >> 2);
    g8  = (int'(p[10:5]) << 2) | (int'(p[10:5]) >> 4);
    b8  = (int'(p[4:0]) << 3) | (int'(p[4:0]) >> 2);
    off = lvl * int'(Step);
    r8  = clamp8(r8 + off);
    g8  = clamp8(g8 + off);
    b8  = clamp8(b8 + off);
    return 16'(((r8 >> 3) << 11) | ((g8 >> 2) << 5) | (b8 >> 3));
  endfunction

  // One clock: drive inputs, advance the model at the edge, sample 1ns later.
  task automatic cycle(input logic [15:0] pix, input logic den, input logic vs,
                       input logic de, input logic ku, input logic kd, input logic r);
    exp_t e;
    bus.rgb_data_i = pix;
    bus.data_en_i  = den;
    bus.vs_in      = vs;
    bus.de_in      = de;
    bus.key_up     = ku;
    bus.key_dn     = kd;
    rst            = r;
    if (!r) exp_q.push_back('{rgb: model_pix(pix, act), sync: {den, vs, de}});
    @(posedge clk);
    if (r) begin
      pend    = 0;
      act     = 0;
      vs_prev = 1'b0;
      exp_q.delete();
      // stage 1 was cleared, so the next output word is all zero
      exp_q.push_back('{rgb: 16'h0, sync: 3'b000});
    end else begin
      if (vs && !vs_prev) act = pend;
      if (ku && !kd && pend < MaxLvl) pend++;
      else if (kd && !ku && pend > -MaxLvl) pend--;
      vs_prev = vs;
    end
    #1;
    if (r) begin
      chk("rst_rgb", bus.rgb_data_o, 16'h0);
      chk("rst_sync", {13'b0, bus.data_en_o, bus.vs_o, bus.de_o}, 16'h0);
    end else if (exp_q.size() == int'(Latency)) begin
      e = exp_q.pop_front();
      chk("rgb_data_o", bus.rgb_data_o, e.rgb);
      chk("sync_o", {13'b0, bus.data_en_o, bus.vs_o, bus.de_o}, {13'b0, e.sync});
      last_rgb = bus.rgb_data_o;
    end
    chk("level_o", {12'b0, bus.level_o}, {12'b0, 4'(act)});
  endtask

  task automatic idle();
    cycle(16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input logic [15:0] p);
    cycle(p, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic up, input logic dn);
    cycle(16'h0, 1'b0, 1'b0, 1'b0, up, dn, 1'b0);
  endtask

  task automatic vs_pulse();
    cycle(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rgb_data_i = '0;
    bus.data_en_i  = 1'b0;
    bus.vs_in      = 1'b0;
    bus.de_in      = 1'b0;
    bus.key_up     = 1'b0;
    bus.key_dn     = 1'b0;
    @(posedge clk);
    #1;

    // Reset
    cycle(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Level 0 pass-through, 2-cycle latency
    pix(16'h1234);
    pix(16'hFFFF);
    chk("pass_1234", last_rgb, 16'h1234);
    pix(16'h0000);
    chk("pass_FFFF", last_rgb, 16'hFFFF);
    idle();
    chk("pass_0000", last_rgb, 16'h0000);

    // One key_up, commit on vs edge
    key(1'b1, 1'b0);
    idle();
    vs_pulse();
    chk("lvl_plus1", {12'b0, bus.level_o}, 16'h0001);
    pix(16'h0000);
    idle();
    chk("plus1_0000", last_rgb, 16'h0841);

    // Back to 0, then -2, then -1
    key(1'b0, 1'b1);
    vs_pulse();
    key(1'b0, 1'b1);
    key(1'b0, 1'b1);
    vs_pulse();
    chk("lvl_minus2", {12'b0, bus.level_o}, 16'h000E);
    key(1'b1, 1'b0);
    vs_pulse();
    chk("lvl_minus1", {12'b0, bus.level_o}, 16'h000F);
    pix(16'hFFFF);
    idle();
    chk("minus1_FFFF", last_rgb, 16'hF7BE);

    for (int i = 0; i < 8; i++) begin
      cycle(16'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    end

    // Saturation high
    for (int i = 0; i < 6; i++) begin
      key(1'b1, 1'b0);
      idle();
    end
    vs_pulse();
    chk("lvl_sat_hi", {12'b0, bus.level_o}, 16'h0004);
    pix(16'hFFFF);
    idle();
    chk("sat_hi_FFFF", last_rgb, 16'hFFFF);
    for (int i = 0; i < 6; i++) pix(16'($urandom));

    // Saturation low
    for (int i = 0; i < 10; i++) key(1'b0, 1'b1);
    vs_pulse();
    chk("lvl_sat_lo", {12'b0, bus.level_o}, 16'h000C);
    pix(16'h0000);
    idle();
    chk("sat_lo_0000", last_rgb, 16'h0000);

    // Mid-frame key has no effect until the next vs edge
    vs_pulse();
    key(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(16'($urandom));
    chk("midframe_lvl", {12'b0, bus.level_o}, 16'h000C);
    key(1'b1, 1'b1);
    // key on the vs edge: commit the pre-update pending level (-3)
    cycle(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("edge_key_lvl", {12'b0, bus.level_o}, 16'h000D);
    idle();
    vs_pulse();
    chk("next_frame_lvl", {12'b0, bus.level_o}, 16'h000E);

    // Reach +3, then reset mid-frame
    for (int i = 0; i < 5; i++) key(1'b1, 1'b0);
    vs_pulse();
    chk("lvl_plus3", {12'b0, bus.level_o}, 16'h0003);
    for (int i = 0; i < 3; i++) pix(16'($urandom));
    cycle(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_level", {12'b0, bus.level_o}, 16'h0000);
    vs_pulse();
    chk("post_rst_lvl", {12'b0, bus.level_o}, 16'h0000);
    pix(16'h1234);
    pix(16'hBEEF);
    chk("post_rst_1234", last_rgb, 16'h1234);
    idle();
    chk("post_rst_BEEF", last_rgb, 16'hBEEF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
